// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and rounding/saturation helpers for the 5x5 convolution engine
package conv_pkg;
    localparam int KERNEL_TAPS = 25;
    localparam int PIX_W       = 8;
    localparam int W_W         = 8;
    localparam int PROD_W      = 17;
    localparam int ROWSUM_W    = 20;
    localparam int BIAS_ADDR   = 25;

    // Round half up, then arithmetic shift; a zero shift leaves the value untouched
    function automatic logic signed [31:0] round_shift(input logic signed [31:0] a, input logic [3:0] sh);
        logic signed [31:0] rnd;
        rnd = (sh == 4'd0) ? 32'sd0 : (32'sd1 <<< (sh - 4'd1));
        return (a + rnd) >>> sh;
    endfunction

    // Two's-complement saturation to -128..127
    function automatic logic [7:0] sat_s8(input logic signed [31:0] a);
        return (a < -32'sd128) ? 8'h80 : (a > 32'sd127) ? 8'h7f : a[7:0];
    endfunction

    // ReLU followed by unsigned saturation to 0..255
    function automatic logic [7:0] relu_u8(input logic signed [31:0] a);
        return (a < 32'sd0) ? 8'h00 : (a > 32'sd255) ? 8'hff : a[7:0];
    endfunction
endpackage

// File: rtl/conv_requant.sv
// conv_requant: final pipeline stage - round, shift and clamp the accumulator to 8 bits (CONV5_RELU_EN selects ReLU/unsigned output)
module conv_requant
    import conv_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    input  logic signed [ACC_W-1:0] i_acc,
    input  logic [3:0]              i_shift,
    output logic [7:0]              o_data,
    output logic                    o_valid
);
    logic signed [31:0] w_acc_ext;
    logic signed [31:0] w_r;
    logic [7:0]         w_q;
    logic [7:0]         r_data;
    logic               r_valid;

    assign w_acc_ext = {{(32-ACC_W){i_acc[ACC_W-1]}}, i_acc};
    assign w_r       = round_shift(w_acc_ext, i_shift);
`ifdef CONV5_RELU_EN
    assign w_q = relu_u8(w_r);
`else
    assign w_q = sat_s8(w_r);
`endif

    // Output register: pixel only changes when a valid result arrives
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) r_data <= w_q;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
endmodule

// File: rtl/conv5x5_engine.sv
// conv5x5_engine: 4-stage 5x5 quantized convolution with frame output counting (CONV5_RELU_EN selects ReLU output in conv_requant)
module conv5x5_engine
    import conv_pkg::*;
#(
    parameter int OUT_W = 24,
    parameter int OUT_H = 24,
    parameter int ACC_W = 24
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [199:0] i_window,
    input  logic         i_window_valid,
    input  logic         i_frame_clr,
    input  logic         i_w_wr,
    input  logic [4:0]   i_w_addr,
    input  logic [15:0]  i_w_data,
    input  logic [3:0]   i_shift,
    output logic [7:0]   o_data,
    output logic         o_valid,
    output logic         o_frame_done,
    output logic         o_busy,
    output logic         o_w_err
);
    localparam int CW = $clog2(OUT_W);
    localparam int RW = $clog2(OUT_H);

    logic signed [W_W-1:0]      r_w [KERNEL_TAPS];
    logic signed [15:0]         r_bias;
    logic signed [PROD_W-1:0]   w_prod [KERNEL_TAPS];
    logic signed [PROD_W-1:0]   r_prod [KERNEL_TAPS];
    logic signed [ROWSUM_W-1:0] w_rsum [5];
    logic signed [ROWSUM_W-1:0] r_rsum [5];
    logic signed [ACC_W-1:0]    w_acc;
    logic signed [ACC_W-1:0]    r_acc;
    logic                       r_v1, r_v2, r_v3, w_v4;
    logic [CW-1:0]              r_col;
    logic [RW-1:0]              r_row;
    logic                       r_w_err, w_wr_tgt, w_wr_ok, w_last;

    assign w_wr_tgt = i_w_wr && (i_w_addr <= 5'(BIAS_ADDR));
    assign w_wr_ok  = w_wr_tgt && !o_busy && !i_window_valid;

    // Coefficient store: writes land only while the pipeline is idle, otherwise flag an error
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int k = 0; k < KERNEL_TAPS; k++) r_w[k] <= '0;
            r_bias  <= '0;
            r_w_err <= 1'b0;
        end else begin
            r_w_err <= w_wr_tgt && !w_wr_ok;
            if (w_wr_ok) begin
                if (i_w_addr == 5'(BIAS_ADDR)) r_bias <= i_w_data;
                else r_w[i_w_addr] <= i_w_data[W_W-1:0];
            end
        end
    end

    // Stage 1 operands: zero-extended pixel times sign-extended weight
    always_comb begin
        for (int k = 0; k < KERNEL_TAPS; k++)
            w_prod[k] = $signed({{(PROD_W-PIX_W){1'b0}}, i_window[PIX_W*k +: PIX_W]})
                      * $signed({{(PROD_W-W_W){r_w[k][W_W-1]}}, r_w[k]});
    end

    // Stage 2 operands: one sum per kernel row
    always_comb begin
        for (int r = 0; r < 5; r++) begin
            w_rsum[r] = '0;
            for (int c = 0; c < 5; c++)
                w_rsum[r] = w_rsum[r] + {{(ROWSUM_W-PROD_W){r_prod[5*r+c][PROD_W-1]}}, r_prod[5*r+c]};
        end
    end

    // Stage 3 operand: row sums plus sign-extended bias
    always_comb begin
        w_acc = {{(ACC_W-16){r_bias[15]}}, r_bias};
        for (int r = 0; r < 5; r++)
            w_acc = w_acc + {{(ACC_W-ROWSUM_W){r_rsum[r][ROWSUM_W-1]}}, r_rsum[r]};
    end

    // Stage valids follow the data every cycle; reset flushes in-flight windows
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            r_v1 <= i_window_valid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
        end
    end

    // Stage data registers, qualified by the valids above
    always_ff @(posedge i_clk) begin
        r_prod <= w_prod;
        r_rsum <= w_rsum;
        r_acc  <= w_acc;
    end

    conv_requant #(.ACC_W(ACC_W)) u_requant (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (r_v3),
        .i_acc   (r_acc),
        .i_shift (i_shift),
        .o_data  (o_data),
        .o_valid (w_v4)
    );

    assign w_last       = (r_col == CW'(OUT_W-1)) && (r_row == RW'(OUT_H-1));
    assign o_valid      = w_v4;
    assign o_frame_done = w_v4 && w_last;
    assign o_busy       = r_v1 | r_v2 | r_v3 | w_v4;
    assign o_w_err      = r_w_err;

    // Output position counters; a frame clear wins over counting the current output
    always_ff @(posedge i_clk) begin
        if (!i_rst || i_frame_clr) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_v4) begin
            if (r_col == CW'(OUT_W-1)) begin
                r_col <= '0;
                r_row <= (r_row == RW'(OUT_H-1)) ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_conv5x5_engine.sv
// tb_conv5x5_engine: randomized and directed self-checking bench for conv5x5_engine
module tb_conv5x5_engine;
    logic         i_clk = 1'b0;
    logic         i_rst = 1'b0;
    logic [199:0] i_window = '0;
    logic         i_window_valid = 1'b0;
    logic         i_frame_clr = 1'b0;
    logic         i_w_wr = 1'b0;
    logic [4:0]   i_w_addr = '0;
    logic [15:0]  i_w_data = '0;
    logic [3:0]   i_shift = '0;
    logic [7:0]   o_data;
    logic         o_valid, o_frame_done, o_busy, o_w_err;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int m_w [25];
    int m_bias = 0;

    typedef struct {int due; logic [7:0] d;} exp_t;

    conv5x5_engine dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_window(i_window), .i_window_valid(i_window_valid),
        .i_frame_clr(i_frame_clr), .i_w_wr(i_w_wr), .i_w_addr(i_w_addr), .i_w_data(i_w_data),
        .i_shift(i_shift), .o_data(o_data), .o_valid(o_valid), .o_frame_done(o_frame_done),
        .o_busy(o_busy), .o_w_err(o_w_err)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    function automatic logic [7:0] model(input logic [199:0] win, input logic [3:0] sh);
        longint acc, r;
        int s;
        s = int'(sh);
        acc = longint'(m_bias);
        for (int k = 0; k < 25; k++) acc += longint'(win[8*k +: 8]) * longint'(m_w[k]);
        if (s == 0) r = acc;
        else r = (acc + (longint'(1) << (s - 1))) >>> s;
`ifdef CONV5_RELU_EN
        return (r < 0) ? 8'd0 : (r > 255) ? 8'd255 : r[7:0];
`else
        return (r < -128) ? 8'h80 : (r > 127) ? 8'h7f : r[7:0];
`endif
    endfunction

    function automatic logic [199:0] fill_win(input int p);
        logic [199:0] w;
        for (int k = 0; k < 25; k++) w[8*k +: 8] = p[7:0];
        return w;
    endfunction

    function automatic logic [199:0] rand_win();
        logic [199:0] w;
        for (int k = 0; k < 25; k++) w[8*k +: 8] = 8'($urandom_range(0, 255));
        return w;
    endfunction

    task automatic wait_idle();
        for (int n = 0; n < 20 && o_busy; n++) tick();
        checks++;
        if (o_busy !== 1'b0) begin
            errs++;
            $display("FAIL idle_wait o_busy=%0b after bound, required 0", o_busy);
        end
    endtask

    task automatic set_w(input int a, input int d);
        i_w_wr = 1'b1;
        i_w_addr = a[4:0];
        i_w_data = d[15:0];
        tick();
        i_w_wr = 1'b0;
        if (a < 25) m_w[a] = int'($signed(d[7:0]));
        else if (a == 25) m_bias = int'($signed(d[15:0]));
    endtask

    task automatic load_all(input int w, input int b, input int s);
        wait_idle();
        for (int k = 0; k < 25; k++) set_w(k, w);
        set_w(25, b);
        i_shift = s[3:0];
    endtask

    task automatic fire(input logic [199:0] win);
        i_window = win;
        i_window_valid = 1'b1;
        tick();
        i_window_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        for (int k = 0; k < 25; k++) m_w[k] = 0;
        m_bias = 0;
        i_rst = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (o_data !== 8'd0 || o_valid !== 1'b0 || o_frame_done !== 1'b0 || o_busy !== 1'b0 || o_w_err !== 1'b0) begin
            errs++;
            $display("FAIL reset_state data=%0h valid=%0b done=%0b busy=%0b werr=%0b, required all 0",
                     o_data, o_valid, o_frame_done, o_busy, o_w_err);
        end
        i_rst = 1'b1;
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            errs++;
            $display("FAIL reset_release valid=%0b busy=%0b, required 0", o_valid, o_busy);
        end
    endtask

    task automatic test_ones();
        load_all(1, 0, 0);
        fire(fill_win(1));
        checks++;
        if (o_valid !== 1'b0) begin
            errs++;
            $display("FAIL ones_early o_valid=%0b at 3 cycles, required 0", o_valid);
        end
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'd25) begin
            errs++;
            $display("FAIL ones valid=%0b data=%0d, required valid=1 data=25", o_valid, o_data);
        end
        tick();
        checks++;
        if (o_valid !== 1'b0) begin
            errs++;
            $display("FAIL ones_single o_valid=%0b one cycle later, required 0", o_valid);
        end
    endtask

    task automatic test_round();
        load_all(0, 0, 1);
        for (int k = 0; k < 5; k++) set_w(k, 1);
        fire(fill_win(1));
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'd3) begin
            errs++;
            $display("FAIL round valid=%0b data=%0d, required valid=1 data=3", o_valid, o_data);
        end
    endtask

    task automatic test_neg();
        logic [7:0] e;
`ifdef CONV5_RELU_EN
        e = 8'h00;
`else
        e = 8'h80;
`endif
        load_all(-1, 0, 0);
        fire(fill_win(10));
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_data !== e) begin
            errs++;
            $display("FAIL negative valid=%0b data=%0h, required valid=1 data=%0h", o_valid, o_data, e);
        end
    endtask

    task automatic test_sat();
        logic [7:0] e;
`ifdef CONV5_RELU_EN
        e = 8'hff;
`else
        e = 8'h7f;
`endif
        load_all(127, 0, 0);
        fire(fill_win(255));
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_data !== e) begin
            errs++;
            $display("FAIL saturate valid=%0b data=%0h, required valid=1 data=%0h", o_valid, o_data, e);
        end
    endtask

    task automatic test_back_to_back();
        exp_t q[$];
        logic [199:0] win;
        for (int b = 0; b < 3; b++) begin
            wait_idle();
            for (int k = 0; k < 25; k++) set_w(k, int'($urandom_range(0, 255)));
            set_w(25, int'($urandom_range(0, 4000)) - 2000);
            i_shift = 4'($urandom_range(2, 10));
            for (int i = 0; i < 66; i++) begin
                if (i < 60 && (b == 0 || $urandom_range(0, 3) != 0)) begin
                    win = rand_win();
                    i_window = win;
                    i_window_valid = 1'b1;
                    q.push_back('{cyc + 4, model(win, i_shift)});
                end else begin
                    i_window_valid = 1'b0;
                end
                tick();
                checks++;
                if (q.size() > 0 && q[0].due == cyc) begin
                    if (o_valid !== 1'b1 || o_data !== q[0].d) begin
                        errs++;
                        $display("FAIL stream burst=%0d cyc=%0d valid=%0b data=%0h, required valid=1 data=%0h",
                                 b, cyc, o_valid, o_data, q[0].d);
                    end
                    void'(q.pop_front());
                end else if (o_valid !== 1'b0) begin
                    errs++;
                    $display("FAIL stream_extra burst=%0d cyc=%0d valid=%0b, required 0", b, cyc, o_valid);
                end
            end
            checks++;
            if (q.size() != 0) begin
                errs++;
                $display("FAIL stream_drain burst=%0d pending=%0d, required 0", b, q.size());
                q.delete();
            end
        end
    endtask

    task automatic test_w_err();
        load_all(1, 0, 0);
        i_window = fill_win(1);
        i_window_valid = 1'b1;
        tick(); tick();
        i_w_wr = 1'b1;
        i_w_addr = 5'd0;
        i_w_data = 16'd9;
        tick();
        checks++;
        if (o_w_err !== 1'b1) begin
            errs++;
            $display("FAIL werr_busy o_w_err=%0b, required 1", o_w_err);
        end
        i_w_addr = 5'd26;
        tick();
        checks++;
        if (o_w_err !== 1'b0) begin
            errs++;
            $display("FAIL werr_ignored_addr o_w_err=%0b, required 0", o_w_err);
        end
        i_w_wr = 1'b0;
        i_window_valid = 1'b0;
        wait_idle();
        fire(fill_win(1));
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'd25) begin
            errs++;
            $display("FAIL werr_weight_kept valid=%0b data=%0d, required valid=1 data=25", o_valid, o_data);
        end
        wait_idle();
        set_w(0, 9);
        checks++;
        if (o_w_err !== 1'b0) begin
            errs++;
            $display("FAIL werr_idle o_w_err=%0b, required 0", o_w_err);
        end
        fire(fill_win(1));
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'd33 || o_data !== model(fill_win(1), i_shift)) begin
            errs++;
            $display("FAIL weight_visible valid=%0b data=%0d, required valid=1 data=33", o_valid, o_data);
        end
    endtask

    task automatic test_frame();
        int nv;
        logic exp_done;
        wait_idle();
        i_frame_clr = 1'b1;
        tick();
        i_frame_clr = 1'b0;
        nv = 0;
        i_window = fill_win(1);
        for (int i = 0; i < 1458; i++) begin
            i_window_valid = (i < 1452);
            tick();
            i_frame_clr = 1'b0;
            if (o_valid === 1'b1) nv++;
            exp_done = (o_valid === 1'b1) && (nv == 576 || nv == 1452);
            checks++;
            if (o_frame_done !== exp_done) begin
                errs++;
                $display("FAIL frame_done output=%0d done=%0b, required %0b", nv, o_frame_done, exp_done);
            end
            if (o_valid === 1'b1 && (nv == 576 || nv == 876)) i_frame_clr = 1'b1;
        end
        i_window_valid = 1'b0;
        i_frame_clr = 1'b0;
        checks++;
        if (nv != 1452) begin
            errs++;
            $display("FAIL frame_count outputs=%0d, required 1452", nv);
        end
    endtask

    task automatic test_reset_mid();
        load_all(1, 0, 0);
        i_window = fill_win(2);
        i_window_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (o_busy !== 1'b1 || o_valid !== 1'b1) begin
            errs++;
            $display("FAIL midrst_pre busy=%0b valid=%0b, required 1 1", o_busy, o_valid);
        end
        i_rst = 1'b0;
        tick();
        for (int k = 0; k < 25; k++) m_w[k] = 0;
        m_bias = 0;
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            errs++;
            $display("FAIL midrst valid=%0b busy=%0b, required 0 0", o_valid, o_busy);
        end
        i_rst = 1'b1;
        i_window_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (o_valid !== 1'b0) begin
                errs++;
                $display("FAIL midrst_flush cyc=%0d valid=%0b, required 0", cyc, o_valid);
            end
        end
        fire(fill_win(9));
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'd0 || o_data !== model(fill_win(9), i_shift)) begin
            errs++;
            $display("FAIL midrst_weights valid=%0b data=%0d, required valid=1 data=0", o_valid, o_data);
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_round();
        test_neg();
        test_sat();
        test_back_to_back();
        test_w_err();
        test_frame();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/conv5x5_engine.md
# conv5x5_engine

- Single-filter 5x5 quantized convolution engine, directly downstream of the 5-line input window buffer.
- Consumes one 25-tap unsigned 8-bit window per valid cycle and produces one requantized 8-bit feature-map pixel per window.
- Fixed 4-stage pipeline: multiply, partial sums, accumulate + bias, requantize.
- Counts outputs per frame and flags frame completion to the layer controller.

## Interface
- OUT_W, 24: output columns per row.
- OUT_H, 24: output rows per frame.
- ACC_W, 24: accumulator width, signed.
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-low.
- i_window  in  200  25 unsigned pixels; tap k at [8k+7:8k], k=0..24 row-major, k=0 top-left.
- i_window_valid  in  1  window qualifier; no backpressure, one window accepted per valid cycle.
- i_frame_clr  in  1  clears output counters (driven by buffer frame interrupt).
- i_w_wr  in  1  weight/bias write strobe.
- i_w_addr  in  5  0..24 = weight tap k; 25 = bias; 26..31 = ignored.
- i_w_data  in  16  weight: [7:0] signed; bias: [15:0] signed.
- i_shift  in  4  requant right-shift, 0..15; sampled in stage 4.
- o_data  out  8  result pixel.
- o_valid  out  1  o_data qualifier.
- o_frame_done  out  1  one-cycle pulse coincident with last o_valid of frame.
- o_busy  out  1  high while any pipeline stage holds valid data.
- o_w_err  out  1  one-cycle pulse: write rejected.

## Operation
- Reset: o_data=0, o_valid=0, o_frame_done=0, o_busy=0, o_w_err=0; all weights and bias =0; stage valids and counters =0.
- S1: 25 products p_k = {0,pix_k} * w_k, 17-bit signed.
- S2: five row sums of 5 products, 20-bit signed.
- S3: sum of row sums + sign-extended bias, ACC_W bits.
- S4 (requant, sub-module):
  - shift==0: r=acc.
  - Otherwise r=(acc + (1<<(shift-1))) >>> shift (arithmetic, round half up).
  - Then clamp per Configuration.
- Writes:
  - Accepted only when o_busy=0 and i_window_valid=0.
  - Otherwise dropped, o_w_err pulses the following cycle.
  - Addresses 26..31 are silently ignored; no error.
- Counters:
  - col 0..OUT_W-1, row 0..OUT_H-1, advance on each o_valid.
  - col wraps at OUT_W-1 and increments row.
  - At col=OUT_W-1 and row=OUT_H-1: o_frame_done pulses with that o_valid, both counters return to 0.
- i_frame_clr:
  - Zeroes counters next cycle; in-flight pipeline data still emerges.
  - Coincident with a final o_valid: done pulse still fires, counters end at 0.
  - Coincident with a non-final o_valid: counter clears and that output is not counted.
- Reset mid-operation: pipeline flushed; no o_valid for discarded windows; weights cleared.

## Timing
- Latency: window at edge N → o_valid/o_data registered at edge N+4.
- Throughput: 1 window/cycle, back-to-back sustained; gaps propagate unchanged.
- o_busy = OR of the four stage-valid bits (registered).
- Weight write visible to the window presented the cycle after the write edge.
- i_shift is not pipelined: its value at stage-4 time applies.

## Configuration
- CONV5_RELU_EN defined:
  - ReLU applied: r<0 → 0, r>255 → 255.
  - o_data unsigned 0..255.
- CONV5_RELU_EN undefined:
  - Signed saturate to -128..127.
  - o_data is two's complement.

## Structure
- Package conv_pkg:
  - Constants KERNEL_TAPS=25, PIX_W=8, W_W=8, PROD_W=17, ROWSUM_W=20, BIAS_ADDR=25.
  - Saturation/rounding helper functions.
- Sub-module conv_requant: stage-4 round, shift and clamp; one register stage; owns the CONV5_RELU_EN behaviour.

## Test plan
- All pixels 1, all weights 1, bias 0, shift 0 → o_data=25 exactly 4 cycles after window.
- Pixels 1, weight 1 on taps 0..4 only, bias 0, shift 1 → sum 5 → o_data=3 (rounded).
- Pixels 10, weights -1, bias 0 → ReLU build 0; non-ReLU build -128 (0x80).
- Pixels 255, weights 127, bias 0, shift 0 → 809625 → 255 (ReLU) / 127 (non-ReLU).
- 576 back-to-back windows → 576 o_valid; o_frame_done only on the 576th; counters at 0; i_frame_clr at output 300 restarts count.
- i_w_wr to tap 0 during streaming → o_w_err pulse, weight unchanged; reset mid-stream → o_valid=0, o_busy=0 next cycle.
